pipeline_id_stage: RTL and testbench
====================================

Name: pipeline_id_stage

Overview:
Parametrised successor to the combinational pipeline_id decode stage. Decodes one RV32I-subset instruction per cycle, reads an internal register file with same-cycle writeback bypass, generates immediates, and registers results into an ID/EX output register. Adds valid/ready handshakes, load-use hazard bubbling and flush. Sits between IF and EX.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN
REG_ADDR_W, 5, register index width; file holds 2**REG_ADDR_W registers
ALU_TYPE_W, 4, alu_type width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  inst/pc valid from IF
in_ready  out  1  stage accepts inst this cycle
inst  in  32  instruction
pc  in  XLEN  instruction address (passed through)
wb_en  in  1  register write enable
wb_rd  in  REG_ADDR_W  write index
wb_data  in  XLEN  write data
flush  in  1  discard output register and current input
out_valid  out  1  ID/EX register holds valid op
out_ready  in  1  EX accepts op
alu_type  out  ALU_TYPE_W  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 NOP=15
rd  out  REG_ADDR_W  destination index
rd_we  out  1  op writes rd
src1  out  XLEN  ALU operand 1
src2  out  XLEN  ALU operand 2 (reg or imm)
store_data  out  XLEN  rs2 value for stores
mem_rd  out  1  load
mem_wr  out  1  store
pc_out  out  XLEN  registered pc
illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset: all outputs 0 except alu_type=15; every register file entry cleared to 0; takes effect on the edge rst is sampled high, including mid-handshake.
- Register file: write on edge when wb_en && wb_rd!=0; x0 always reads 0. Read bypass: if wb_en && wb_rd==rsX && rsX!=0, operand = wb_data in the same cycle. Writes proceed during stall and flush.
- Decode: R (0110011) funct3/funct7 -> ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, src2=rs2 value. I-ALU (0010011) same ops, src2=imm[31:20] sign-ext; SLLI/SRLI/SRAI use shamt inst[24:20], funct7 bit 30 selects SRA. LOAD (0000011): ADD, src2=I-imm, mem_rd=1. STORE (0100011): ADD, src2=S-imm, store_data=rs2, mem_wr=1, rd_we=0. LUI (0110111): ADD, src1=0, src2={inst[31:12],12'b0} sign-ext. Any other opcode or invalid funct7: illegal=1, alu_type=15, rd_we=mem_rd=mem_wr=0.
- advance = !out_valid || out_ready.
- hazard = out_valid && mem_rd && rd!=0 && (rd==rs1 || (rd==rs2 && opcode uses rs2: R or STORE)).
- in_ready = advance && !hazard && !flush.
- Latency 1: accepted inst appears on outputs the next cycle.
- On advance edge: if flush -> out_valid=0; else if hazard -> bubble (out_valid=0, alu_type=15); else if in_valid -> load decoded op, out_valid=1; else out_valid=0.
- !advance: output register holds all values stable.
- Flush priority over hazard, stall and new input; flush while !advance still clears out_valid.

Test Plan:
- Reset then R-type ADD x3=x1+x2 with empty file -> next cycle out_valid=1, alu_type=0, src1=0, src2=0, rd=3.
- ADD rs1=5 with wb_en=1, wb_rd=5, wb_data=12 same cycle -> src1=12, src2=0; later read of x5 returns 12; wb to x0 with 99 -> x0 reads 0.
- ADDI x1,x0,-1 -> src2=0xFFFFFFFF; SRAI x2,x1,4 -> alu_type=7, src2=4; LUI x4,0x12345 -> src2=0x12345000.
- LW x6 then ADD x7,x6,x6 back-to-back, out_ready=1 -> in_ready=0 one cycle, one bubble (out_valid=0), ADD issued the following cycle; same with rd=x0 -> no bubble.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> next op issues.
- flush=1 with valid op held and in_valid=1 -> next cycle out_valid=0, input not accepted; opcode 1111111 -> illegal=1, alu_type=15.

Source files
------------

// File: rtl/pipeline_id_stage.sv
// pipeline_id_stage: RV32I-subset decode with bypassed register file, load-use bubbling and a
// valid/ready ID/EX output register.
module pipeline_id_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_TYPE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  input  logic [XLEN-1:0]       pc,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_TYPE_W-1:0] alu_type,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  rd_we,
  output logic [XLEN-1:0]       src1,
  output logic [XLEN-1:0]       src2,
  output logic [XLEN-1:0]       store_data,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [XLEN-1:0]       pc_out,
  output logic                  illegal
);
  typedef logic [ALU_TYPE_W-1:0] alu_t;
  localparam alu_t ADD = alu_t'(0), SUB = alu_t'(1), SLL = alu_t'(2), SLT = alu_t'(3),
                   SLTU = alu_t'(4), XOR = alu_t'(5), SRL = alu_t'(6), SRA = alu_t'(7),
                   OR = alu_t'(8), AND = alu_t'(9), NOP = alu_t'(15);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_LUI = 7'b0110111;
  logic [XLEN-1:0]       r_rf [2**REG_ADDR_W];
  logic                  r_valid, r_rd_we, r_mrd, r_mwr, r_ill;
  alu_t                  r_alu;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_src1, r_src2, r_sd, r_pc;
  logic [6:0]            w_opc, w_f7;
  logic [2:0]            w_f3;
  logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
  logic signed [11:0]    w_i12, w_s12;
  logic signed [31:0]    w_u32;
  logic [XLEN-1:0]       w_v1, w_v2, w_imm_i, w_imm_s, w_imm_u, w_shamt, w_src1, w_src2;
  alu_t                  w_aop, w_alu;
  logic                  w_f7_r, w_f7_i, w_rd_we, w_mrd, w_mwr, w_ill, w_use2, w_adv, w_haz;
  assign w_opc   = inst[6:0];
  assign w_f3    = inst[14:12];
  assign w_f7    = inst[31:25];
  assign w_rd    = REG_ADDR_W'(inst[11:7]);
  assign w_rs1   = REG_ADDR_W'(inst[19:15]);
  assign w_rs2   = REG_ADDR_W'(inst[24:20]);
  assign w_i12   = inst[31:20];
  assign w_s12   = {inst[31:25], inst[11:7]};
  assign w_u32   = {inst[31:12], 12'b0};
  assign w_imm_i = XLEN'(w_i12);
  assign w_imm_s = XLEN'(w_s12);
  assign w_imm_u = XLEN'(w_u32);
  assign w_shamt = XLEN'(inst[24:20]);
  // Writeback in the same cycle is forwarded so the operand never sees a stale file entry.
  assign w_v1 = (w_rs1 == '0) ? '0 : (wb_en && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1];
  assign w_v2 = (w_rs2 == '0) ? '0 : (wb_en && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2];
  assign w_f7_r = (w_f7 == 7'b0) || (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5));
  assign w_f7_i = (w_f3 == 3'd1) ? (w_f7 == 7'b0) :
                  (w_f3 == 3'd5) ? (w_f7 == 7'b0 || w_f7 == 7'b0100000) : 1'b1;
  always_comb begin
    case (w_f3)
      3'd0:    w_aop = (w_opc == OP_R && inst[30]) ? SUB : ADD;
      3'd1:    w_aop = SLL;
      3'd2:    w_aop = SLT;
      3'd3:    w_aop = SLTU;
      3'd4:    w_aop = XOR;
      3'd5:    w_aop = inst[30] ? SRA : SRL;
      3'd6:    w_aop = OR;
      default: w_aop = AND;
    endcase
  end
  always_comb begin
    w_alu   = NOP;
    w_src1  = w_v1;
    w_src2  = w_v2;
    w_rd_we = 1'b0;
    w_mrd   = 1'b0;
    w_mwr   = 1'b0;
    w_ill   = 1'b0;
    case (w_opc)
      OP_R: begin
        w_ill   = !w_f7_r;
        w_alu   = w_f7_r ? w_aop : NOP;
        w_rd_we = w_f7_r;
      end
      OP_I: begin
        w_ill   = !w_f7_i;
        w_alu   = w_f7_i ? w_aop : NOP;
        w_rd_we = w_f7_i;
        w_src2  = (w_f3 == 3'd1 || w_f3 == 3'd5) ? w_shamt : w_imm_i;
      end
      OP_LD: begin
        w_alu   = ADD;
        w_rd_we = 1'b1;
        w_mrd   = 1'b1;
        w_src2  = w_imm_i;
      end
      OP_ST: begin
        w_alu  = ADD;
        w_mwr  = 1'b1;
        w_src2 = w_imm_s;
      end
      OP_LUI: begin
        w_alu   = ADD;
        w_rd_we = 1'b1;
        w_src1  = '0;
        w_src2  = w_imm_u;
      end
      default: w_ill = 1'b1;
    endcase
  end
  assign w_use2   = (w_opc == OP_R) || (w_opc == OP_ST);
  assign w_adv    = !r_valid || out_ready;
  assign w_haz    = r_valid && r_mrd && r_rd != '0 && (r_rd == w_rs1 || (r_rd == w_rs2 && w_use2));
  assign in_ready = !rst && w_adv && !w_haz && !flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) r_rf[i] <= '0;
      r_valid <= 1'b0;
      r_alu   <= NOP;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_sd    <= '0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_pc    <= '0;
      r_ill   <= 1'b0;
    end else begin
      if (wb_en && wb_rd != '0) r_rf[wb_rd] <= wb_data;
      if (flush) r_valid <= 1'b0;
      else if (w_adv) begin
        if (w_haz) begin
          r_valid <= 1'b0;
          r_alu   <= NOP;
          r_rd_we <= 1'b0;
          r_mrd   <= 1'b0;
          r_mwr   <= 1'b0;
        end else if (in_valid) begin
          r_valid <= 1'b1;
          r_alu   <= w_alu;
          r_rd    <= w_rd;
          r_rd_we <= w_rd_we;
          r_src1  <= w_src1;
          r_src2  <= w_src2;
          r_sd    <= w_v2;
          r_mrd   <= w_mrd;
          r_mwr   <= w_mwr;
          r_pc    <= pc;
          r_ill   <= w_ill;
        end else r_valid <= 1'b0;
      end
    end
  end
  assign out_valid  = r_valid;
  assign alu_type   = r_alu;
  assign rd         = r_rd;
  assign rd_we      = r_rd_we;
  assign src1       = r_src1;
  assign src2       = r_src2;
  assign store_data = r_sd;
  assign mem_rd     = r_mrd;
  assign mem_wr     = r_mwr;
  assign pc_out     = r_pc;
  assign illegal    = r_ill;
endmodule

// File: tb/tb_pipeline_id_stage.sv
// tb_pipeline_id_stage: directed decode vectors plus load-use, stall, flush and reset sequences.
module tb_pipeline_id_stage;
  logic        clk = 0, rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic [31:0] inst, pc, wb_data, src1, src2, store_data, pc_out;
  logic [4:0]  wb_rd, rd;
  logic [3:0]  alu_type;
  logic        rd_we, mem_rd, mem_wr, illegal;
  int          n_run = 0, n_fail = 0;
  typedef struct {
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        we, mrd, mwr, ill, cs;
    logic [31:0] s1, s2, sd;
  } vec_t;
  vec_t v[16];
  pipeline_id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_type(alu_type), .rd(rd), .rd_we(rd_we), .src1(src1),
    .src2(src2), .store_data(store_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_out(pc_out),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  initial begin
    v[0]  = '{32'h002081B3, 0, 0, 0,            0, 3,  1, 0, 0, 0, 1, 0,            0,            0};
    v[1]  = '{32'h00028433, 1, 5, 12,           0, 8,  1, 0, 0, 0, 1, 12,           0,            0};
    v[2]  = '{32'h405284B3, 0, 0, 0,            1, 9,  1, 0, 0, 0, 1, 12,           12,           12};
    v[3]  = '{32'h00000533, 1, 0, 99,           0, 10, 1, 0, 0, 0, 1, 0,            0,            0};
    v[4]  = '{32'h000005B3, 0, 0, 0,            0, 11, 1, 0, 0, 0, 1, 0,            0,            0};
    v[5]  = '{32'hFFF00093, 1, 1, 32'hFFFFFFFF, 0, 1,  1, 0, 0, 0, 1, 0,            32'hFFFFFFFF, 0};
    v[6]  = '{32'h4040D113, 0, 0, 0,            7, 2,  1, 0, 0, 0, 1, 32'hFFFFFFFF, 4,            0};
    v[7]  = '{32'h12345237, 0, 0, 0,            0, 4,  1, 0, 0, 0, 1, 0,            32'h12345000, 0};
    v[8]  = '{32'h800002B7, 0, 0, 0,            0, 5,  1, 0, 0, 0, 1, 0,            32'h80000000, 0};
    v[9]  = '{32'h0082A303, 0, 0, 0,            0, 6,  1, 1, 0, 0, 1, 12,           8,            0};
    v[10] = '{32'hFE12AE23, 0, 0, 0,            0, 28, 0, 0, 1, 0, 1, 12,           32'hFFFFFFFC, 32'hFFFFFFFF};
    v[11] = '{32'h0000007F, 0, 0, 0,            15, 0, 0, 0, 0, 1, 0, 0,            0,            0};
    v[12] = '{32'h020081B3, 0, 0, 0,            15, 3, 0, 0, 0, 1, 0, 0,            0,            0};
    v[13] = '{32'h0050B1B3, 0, 0, 0,            4, 3,  1, 0, 0, 0, 1, 32'hFFFFFFFF, 12,           12};
    v[14] = '{32'h7FF2C393, 0, 0, 0,            5, 7,  1, 0, 0, 0, 1, 12,           32'h7FF,      0};
    v[15] = '{32'h0012F633, 0, 0, 0,            9, 12, 1, 0, 0, 0, 1, 12,           32'hFFFFFFFF, 32'hFFFFFFFF};
    rst = 1; in_valid = 0; inst = 0; pc = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst alu_type", 32'(alu_type), 15);
    chk("rst rd", 32'(rd), 0);
    chk("rst src1", src1, 0);
    chk("rst src2", src2, 0);
    chk("rst pc_out", pc_out, 0);
    chk("rst ctrl", {28'd0, rd_we, mem_rd, mem_wr, illegal}, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      inst = v[i].inst; pc = 32'h1000 + 32'(4 * i); in_valid = 1;
      wb_en = v[i].wb_en; wb_rd = v[i].wb_rd; wb_data = v[i].wb_data;
      #1 chk($sformatf("v%0d in_ready", i), 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 0; wb_en = 0;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d alu_type", i), 32'(alu_type), 32'(v[i].alu));
      chk($sformatf("v%0d rd", i), 32'(rd), 32'(v[i].rd));
      chk($sformatf("v%0d ctrl", i), {28'd0, rd_we, mem_rd, mem_wr, illegal},
          {28'd0, v[i].we, v[i].mrd, v[i].mwr, v[i].ill});
      chk($sformatf("v%0d pc_out", i), pc_out, 32'h1000 + 32'(4 * i));
      if (v[i].cs) begin
        chk($sformatf("v%0d src1", i), src1, v[i].s1);
        chk($sformatf("v%0d src2", i), src2, v[i].s2);
        chk($sformatf("v%0d store_data", i), store_data, v[i].sd);
      end
      @(negedge clk);
    end
    // Load-use on x6: one bubble, then the dependent ADD issues.
    inst = 32'h0082A303; in_valid = 1;
    #1 chk("lu lw in_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("lu lw out", {out_valid, mem_rd, 27'd0, rd}, {1'b1, 1'b1, 27'd0, 5'd6});
    inst = 32'h006303B3;
    #1 chk("lu hazard in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("lu bubble valid", 32'(out_valid), 0);
    chk("lu bubble alu", 32'(alu_type), 15);
    #1 chk("lu after in_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("lu add issued", {out_valid, 22'd0, alu_type, rd}, {1'b1, 22'd0, 4'd0, 5'd7});
    in_valid = 0;
    @(negedge clk);
    // Load into x0 never creates a hazard.
    inst = 32'h0082A003; in_valid = 1;
    @(negedge clk);
    inst = 32'h000003B3;
    #1 chk("lu0 in_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("lu0 add issued", {out_valid, 26'd0, rd}, {1'b1, 26'd0, 5'd7});
    in_valid = 0;
    @(negedge clk);
    // Downstream stall for three cycles.
    inst = 32'h002081B3; in_valid = 1; pc = 32'h2000;
    @(negedge clk);
    out_ready = 0; inst = 32'h405284B3; pc = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d in_ready", c), 32'(in_ready), 0);
      @(negedge clk);
      chk($sformatf("stall%0d held", c), {out_valid, 22'd0, alu_type, rd}, {1'b1, 22'd0, 4'd0, 5'd3});
      chk($sformatf("stall%0d pc", c), pc_out, 32'h2000);
    end
    out_ready = 1;
    #1 chk("stall release in_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("stall next op", {out_valid, 22'd0, alu_type, rd}, {1'b1, 22'd0, 4'd1, 5'd9});
    // Flush while held and with new input offered.
    out_ready = 0; flush = 1; inst = 32'h002081B3;
    #1 chk("flush in_ready", 32'(in_ready), 0);
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush out_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("flush no late issue", 32'(out_valid), 0);
    // Reset mid-handshake clears output and register file.
    inst = 32'h00028433; in_valid = 1; out_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0; out_ready = 1;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst alu", 32'(alu_type), 15);
    @(negedge clk);
    in_valid = 0;
    chk("midrst x5 cleared", src1, 0);
    chk("midrst issued", 32'(out_valid), 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
